// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode seven-segment scan driver with hex decode, decimal points,
// leading-zero suppression and per-digit blinking; inputs are snapshotted once per frame.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] number,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [7:0]              SEG,
    output logic                    frame_done
);

    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    // Segment pattern g..a, active low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [PRE_W-1:0]        presc_p0;
    logic [SEL_W-1:0]        sel_p0;
    logic [FRM_W-1:0]        frm_cnt_p0;
    logic                    blink_phase_p0;
    logic                    primed;
    logic [4*NUM_DIGITS-1:0] sh_number_p0;
    logic [NUM_DIGITS-1:0]   sh_dp_p0;
    logic [NUM_DIGITS-1:0]   sh_blink_p0;
    logic                    sh_blank_lz_p0;
    logic [NUM_DIGITS-1:0]   an_p1;
    logic [7:0]              seg_p1;
    logic                    frame_done_p1;

    logic                    tick;
    logic                    frame_wrap;
    logic                    load;
    logic [NUM_DIGITS-1:0]   lead;
    logic                    above;
    logic [3:0]              nib;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [7:0]              seg_d;

    // The prescaler stays parked until the priming load so digit 0 gets a full slot.
    assign tick       = primed && (presc_p0 == PRE_LAST);
    assign frame_wrap = tick && (sel_p0 == SEL_LAST);
    assign load       = !primed || frame_wrap;

    // p0 -> p1: leading-zero chain, blanking and decode of the selected digit
    always_comb begin
        lead  = '0;
        above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            above   = above && (sh_number_p0[4*i +: 4] == 4'h0) && !sh_dp_p0[i];
            lead[i] = above;
        end
        lead[0] = 1'b0;

        nib   = sh_number_p0[{sel_p0, 2'b00} +: 4];
        blank = !primed
              || (sh_blank_lz_p0 && lead[sel_p0])
              || (sh_blink_p0[sel_p0] && blink_phase_p0);

        an_d  = '1;
        seg_d = 8'hFF;
        if (!blank) begin
            an_d[sel_p0] = 1'b0;
            seg_d        = {~sh_dp_p0[sel_p0], hex_to_seg(nib)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_p0       <= '0;
            sel_p0         <= '0;
            frm_cnt_p0     <= '0;
            blink_phase_p0 <= 1'b0;
            primed         <= 1'b0;
            sh_number_p0   <= '0;
            sh_dp_p0       <= '0;
            sh_blink_p0    <= '0;
            sh_blank_lz_p0 <= 1'b0;
            an_p1          <= '1;
            seg_p1         <= 8'hFF;
            frame_done_p1  <= 1'b0;
        end else begin
            primed        <= 1'b1;
            frame_done_p1 <= frame_wrap;
            an_p1         <= an_d;
            seg_p1        <= seg_d;

            if (primed)
                presc_p0 <= tick ? '0 : presc_p0 + 1'b1;
            if (tick)
                sel_p0 <= (sel_p0 == SEL_LAST) ? '0 : sel_p0 + 1'b1;

            if (load) begin
                sh_number_p0   <= number;
                sh_dp_p0       <= dp;
                sh_blink_p0    <= blink;
                sh_blank_lz_p0 <= blank_lz;
            end

            if (frame_wrap) begin
                if (frm_cnt_p0 == FRM_LAST) begin
                    frm_cnt_p0     <= '0;
                    blink_phase_p0 <= ~blink_phase_p0;
                end else begin
                    frm_cnt_p0 <= frm_cnt_p0 + 1'b1;
                end
            end
        end
    end

    assign AN         = an_p1;
    assign SEG        = seg_p1;
    assign frame_done = frame_done_p1;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues per-cycle expected AN/SEG/frame_done,
// a negedge monitor pops and compares.
module tb_seg7_scan_ctrl;

    localparam int ND = 8;
    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] number;
    logic [7:0]  dp;
    logic [7:0]  blink;
    logic        blank_lz;
    logic [7:0]  AN;
    logic [7:0]  SEG;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .number    (number),
        .dp        (dp),
        .blink     (blink),
        .blank_lz  (blank_lz),
        .AN        (AN),
        .SEG       (SEG),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic logic [7:0] seg_of(input logic [3:0] h);
        logic [7:0] tab [16];
        tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return tab[h];
    endfunction

    function automatic logic [7:0] an_of(input int k);
        logic [7:0] v;
        v    = 8'hFF;
        v[k] = 1'b0;
        return v;
    endfunction

    task automatic push(input logic [7:0] an, input logic [7:0] seg, input logic fd,
                        input string nm);
        exp_t e;
        e.an  = an;
        e.seg = seg;
        e.fd  = fd;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic push_slot(input int k, input logic lit, input logic [7:0] seg,
                             input logic last, input string nm);
        for (int c = 0; c < SD; c++) begin
            if (lit) push(an_of(k), seg, last && (c == SD - 1), nm);
            else     push(8'hFF, 8'hFF, last && (c == SD - 1), nm);
        end
    endtask

    task automatic push_frame(input logic [7:0] lit, input logic [63:0] segs, input string nm);
        for (int k = 0; k < ND; k++)
            push_slot(k, lit[k], segs[8*k +: 8], k == ND - 1, nm);
    endtask

    task automatic drain(input int limit);
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < limit) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries still pending, required 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_tests++;
            if (AN !== e.an || SEG !== e.seg || frame_done !== e.fd) begin
                n_fail++;
                $display("FAIL %s: got AN=%h SEG=%h frame_done=%b, required AN=%h SEG=%h frame_done=%b",
                         nm, AN, SEG, frame_done, e.an, e.seg, e.fd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        number   = 32'h7654_3210;
        dp       = 8'h00;
        blink    = 8'h00;
        blank_lz = 1'b0;
        @(negedge clk);
        #1;
        push(8'hFF, 8'hFF, 1'b0, "reset");
        push(8'hFF, 8'hFF, 1'b0, "reset");
        drain(20);

        // Release: one priming cycle, then digits 0..3 of frame 0.
        rst = 1'b0;
        push(8'hFF, 8'hFF, 1'b0, "prime");
        for (int k = 0; k < 4; k++) push_slot(k, 1'b1, seg_of(4'(k)), 1'b0, "scan");
        drain(100);

        // Input change while digit 3 shows must not reach digits 4..7.
        number = 32'hFFFF_FFFF;
        for (int k = 4; k < 8; k++) push_slot(k, 1'b1, seg_of(4'(k)), k == 7, "snapshot");
        drain(100);

        number   = 32'h0000_0A05;
        blank_lz = 1'b1;
        push_frame(8'hFF, 64'h8E8E8E8E8E8E8E8E, "all_F");
        drain(100);

        number = 32'h0000_0000;
        push_frame(8'h07, 64'hFFFFFFFFFF88C092, "lz_A05");
        drain(100);

        dp = 8'h20;
        push_frame(8'h01, 64'hFFFFFFFFFFFFFFC0, "lz_zero");
        drain(100);

        push_frame(8'h3F, 64'hFFFF40C0C0C0C0C0, "lz_dp5");
        drain(100);

        // Next frame up to the first cycle of digit 5, then reset while selector sits at 5.
        for (int k = 0; k < 5; k++) push_slot(k, 1'b1, 8'hC0, 1'b0, "pre_rst");
        push(an_of(5), 8'h40, 1'b0, "pre_rst");
        drain(100);

        rst = 1'b1;
        push(8'hFF, 8'hFF, 1'b0, "mid_rst");
        drain(10);

        number   = 32'h7654_3210;
        dp       = 8'h00;
        blink    = 8'h01;
        blank_lz = 1'b0;
        push(8'hFF, 8'hFF, 1'b0, "rst_hold");
        drain(10);

        rst = 1'b0;
        push(8'hFF, 8'hFF, 1'b0, "reprime");
        push_frame(8'hFF, 64'hF8829299B0A4F9C0, "blink_f0");
        push_frame(8'hFF, 64'hF8829299B0A4F9C0, "blink_f1");
        push_frame(8'hFE, 64'hF8829299B0A4F9FF, "blink_f2");
        push_frame(8'hFE, 64'hF8829299B0A4F9FF, "blink_f3");
        push_frame(8'hFF, 64'hF8829299B0A4F9C0, "blink_f4");
        drain(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
